// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch (I) and data (D) ports.
// Data has priority, a streak counter forces a fetch grant, and a watchdog completes unacknowledged accesses.
module mem_port_arbiter #(
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  localparam int DS_W = $clog2(MAX_DSTREAK + 1);
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [DS_W-1:0] DS_MAX  = DS_W'(MAX_DSTREAK);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t            state_reg, state_next;
  owner_t            own_reg, own_next;
  logic [DS_W-1:0]   dstreak_reg, dstreak_next;
  logic [WC_W-1:0]   wcnt_reg, wcnt_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [DATA_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0] i_rdata_reg, i_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;
  logic              i_ready_reg, i_ready_next;
  logic              d_ready_reg, d_ready_next;
  logic              err_reg, err_next;
  logic              busy_reg, busy_next;

  logic              grant_d;
  logic              finish;
  logic              timed_out;
  logic [DATA_W-1:0] result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      own_reg       <= OWN_I;
      dstreak_reg   <= '0;
      wcnt_reg      <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      i_rdata_reg   <= '0;
      d_rdata_reg   <= '0;
      i_ready_reg   <= 1'b0;
      d_ready_reg   <= 1'b0;
      err_reg       <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      own_reg       <= own_next;
      dstreak_reg   <= dstreak_next;
      wcnt_reg      <= wcnt_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      i_rdata_reg   <= i_rdata_next;
      d_rdata_reg   <= d_rdata_next;
      i_ready_reg   <= i_ready_next;
      d_ready_reg   <= d_ready_next;
      err_reg       <= err_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    own_next       = own_reg;
    dstreak_next   = dstreak_reg;
    wcnt_next      = wcnt_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    i_rdata_next   = i_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    i_ready_next   = 1'b0;
    d_ready_next   = 1'b0;
    err_next       = 1'b0;
    grant_d        = 1'b0;
    finish         = 1'b0;
    timed_out      = 1'b0;
    result         = '0;

    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          if (i_req && !d_req) begin
            grant_d      = 1'b0;
            dstreak_next = '0;
          end else if (!i_req) begin
            grant_d = 1'b1;
          end else if (dstreak_reg == DS_MAX) begin
            // Contested and the data streak is exhausted: fetch gets its turn.
            grant_d      = 1'b0;
            dstreak_next = '0;
          end else begin
            grant_d      = 1'b1;
            dstreak_next = dstreak_reg + DS_W'(1);
          end
          own_next       = grant_d ? OWN_D : OWN_I;
          mem_req_next   = 1'b1;
          mem_we_next    = grant_d & d_we;
          mem_addr_next  = grant_d ? d_addr : i_addr;
          mem_wdata_next = grant_d ? d_wdata : '0;
          wcnt_next      = '0;
          state_next     = BUSY;
        end
      end

      BUSY: begin
        if (mem_ack) begin
          finish = 1'b1;
          result = mem_rdata;
        end else if (wcnt_reg == WC_LAST) begin
          finish    = 1'b1;
          timed_out = 1'b1;
        end else begin
          wcnt_next = wcnt_reg + WC_W'(1);
        end

        if (finish) begin
          mem_req_next = 1'b0;
          err_next     = timed_out;
          state_next   = DONE;
          if (own_reg == OWN_D) begin
            d_ready_next = 1'b1;
            // Stores leave the last load result untouched.
            if (!mem_we_reg) begin
              d_rdata_next = result;
            end
          end else begin
            i_ready_next = 1'b1;
            i_rdata_next = result;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign i_rdata   = i_rdata_reg;
  assign i_ready   = i_ready_reg;
  assign d_rdata   = d_rdata_reg;
  assign d_ready   = d_ready_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed stimulus for mem_port_arbiter, checked every cycle against a
// transaction-level model: grant decision, ack delay and completion cycle computed arithmetically.
module tb_mem_port_arbiter;

  localparam int DW   = 32;
  localparam int MAXD = 4;
  localparam int TMO  = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [DW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [DW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(DW), .MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int txn_n = 0;

  // model of the access in flight, indexed by c = cycles since the grant edge
  bit          m_busy = 0;
  int          m_c = 0, m_len = 0, m_k = 0, m_streak = 0;
  bit          m_own_d = 0, m_to = 0;
  logic [31:0] m_rd = '0;
  logic [31:0] exp_mem_addr = '0, exp_mem_wdata = '0, exp_i_rdata = '0, exp_d_rdata = '0;
  bit          exp_mem_we = 0, exp_mem_req = 0, exp_busy = 0;
  bit          exp_i_ready = 0, exp_d_ready = 0, exp_err = 0;

  // stimulus knobs; force_k: -1 random, -2 never ack, >=0 fixed ack delay
  bit          i_pend = 0, i_drop = 0, d_pend = 0, d_drop = 0;
  bit          i_en = 0, d_en = 0, i_always = 0, d_always = 0, drop_en = 0;
  int          force_k = 0;
  bit          ovr_en = 0;
  logic [31:0] ovr_data = '0;
  logic [31:0] i_base = '0, d_base = '0;

  bit          rec_grants = 0;
  logic        prev_mreq = 1'b0;
  int          gq[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_streak = 0;
    exp_mem_addr = '0; exp_mem_wdata = '0; exp_i_rdata = '0; exp_d_rdata = '0;
    exp_mem_we = 0; exp_mem_req = 0; exp_busy = 0;
    exp_i_ready = 0; exp_d_ready = 0; exp_err = 0;
  endtask

  task automatic model_edge();
    exp_i_ready = 0; exp_d_ready = 0; exp_err = 0;
    if (m_busy) begin
      m_c++;
      if (m_c == m_len + 1) begin
        if (m_own_d) begin
          exp_d_ready = 1;
          if (!exp_mem_we) exp_d_rdata = m_to ? 32'h0 : m_rd;
        end else begin
          exp_i_ready = 1;
          exp_i_rdata = m_to ? 32'h0 : m_rd;
        end
        exp_err = m_to;
        txn_n++;
        $display("txn %0d: %s addr=%h we=%0d wait=%0d rdata=%h timeout=%0d",
                 txn_n, m_own_d ? "D" : "I", exp_mem_addr, exp_mem_we, m_len,
                 m_to ? 32'h0 : m_rd, m_to);
      end
      if (m_c == m_len + 2) m_busy = 0;
    end else if (i_req || d_req) begin
      if (i_req && d_req) begin
        m_own_d  = (m_streak != MAXD);
        m_streak = m_own_d ? m_streak + 1 : 0;
      end else if (i_req) begin
        m_own_d = 0; m_streak = 0;
      end else begin
        m_own_d = 1;
      end
      exp_mem_addr  = m_own_d ? d_addr : i_addr;
      exp_mem_we    = m_own_d && d_we;
      exp_mem_wdata = m_own_d ? d_wdata : 32'h0;
      if (force_k == -2 || (force_k == -1 && $urandom_range(0, 19) == 0)) begin
        m_to = 1; m_k = 0; m_len = TMO;
      end else begin
        m_to = 0;
        m_k = (force_k >= 0) ? force_k : int'($urandom_range(0, 4));
        m_len = m_k + 1;
      end
      m_rd   = ovr_en ? ovr_data : memfn(exp_mem_addr);
      m_busy = 1;
      m_c    = 1;
    end
    exp_mem_req = m_busy && (m_c <= m_len);
    exp_busy    = m_busy && (m_c <= m_len + 1);
  endtask

  task automatic compare_outputs();
    check_eq("mem_req", 32'(mem_req), 32'(exp_mem_req));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("i_ready", 32'(i_ready), 32'(exp_i_ready));
    check_eq("d_ready", 32'(d_ready), 32'(exp_d_ready));
    check_eq("err", 32'(err), 32'(exp_err));
    check_eq("mem_we", 32'(mem_we), 32'(exp_mem_we));
    check_eq("mem_addr", mem_addr, exp_mem_addr);
    check_eq("mem_wdata", mem_wdata, exp_mem_wdata);
    check_eq("i_rdata", i_rdata, exp_i_rdata);
    check_eq("d_rdata", d_rdata, exp_d_rdata);
    if (rec_grants && mem_req === 1'b1 && prev_mreq !== 1'b1) gq.push_back(int'(mem_addr[31:28]));
    prev_mreq = mem_req;
  endtask

  task automatic drive();
    if (exp_i_ready) begin i_pend = 0; i_drop = 0; end
    if (exp_d_ready) begin d_pend = 0; d_drop = 0; end
    if (!i_pend && i_en && (i_always || $urandom_range(0, 2) == 0)) begin
      i_pend = 1;
      i_addr = i_base | ($urandom & 32'h0FFF_FFFC);
    end
    if (!d_pend && d_en && (d_always || $urandom_range(0, 2) == 0)) begin
      d_pend  = 1;
      d_addr  = d_base | ($urandom & 32'h0FFF_FFFC);
      d_we    = 1'($urandom_range(0, 1));
      d_wdata = $urandom;
    end
    if (drop_en && m_busy && m_c <= m_len && $urandom_range(0, 9) == 0) begin
      if (m_own_d) d_drop = d_pend;
      else         i_drop = i_pend;
    end
    i_req = i_pend && !i_drop;
    d_req = d_pend && !d_drop;

    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (m_busy && !m_to && m_c == m_k + 1) begin
      mem_ack   = 1'b1;
      mem_rdata = m_rd;
    end else if (m_busy && m_c == m_len + 1) begin
      mem_ack = 1'($urandom_range(0, 1));      // stray ack in DONE
    end else if (!m_busy) begin
      mem_ack = ($urandom_range(0, 3) == 0);   // stray ack in IDLE
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
    drive();
  endtask

  task automatic wait_quiet(input string tag, input int max_cycles);
    int n = 0;
    while ((m_busy || i_pend || d_pend) && n < max_cycles) begin
      step();
      n++;
    end
    check_eq(tag, 32'(m_busy || i_pend || d_pend), 32'h0);
  endtask

  int          lat, mc;
  logic [31:0] rst_addr;

  initial begin
    // power-on reset
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    compare_outputs();
    reset = 1'b1;

    // single fetch, zero-wait memory
    ovr_en = 1; ovr_data = 32'h8C220004; force_k = 0;
    i_pend = 1; i_addr = 32'h40; i_req = 1'b1;
    step();
    check_eq("fetch_mem_req", 32'(mem_req), 32'h1);
    check_eq("fetch_mem_addr", mem_addr, 32'h40);
    check_eq("fetch_mem_we", 32'(mem_we), 32'h0);
    check_eq("fetch_early_ready", 32'(i_ready), 32'h0);
    step();
    check_eq("fetch_i_ready", 32'(i_ready), 32'h1);
    check_eq("fetch_i_rdata", i_rdata, 32'h8C220004);
    ovr_en = 0;
    wait_quiet("fetch_quiet", 10);

    // load with ack in the second mem_req cycle
    force_k = 1;
    d_pend = 1; d_addr = 32'h180; d_we = 1'b0; d_wdata = 32'hDEAD; d_req = 1'b1;
    lat = 0;
    for (int j = 0; j < 20 && !exp_d_ready; j++) begin step(); lat++; end
    check_eq("load_latency", 32'(lat), 32'd3);
    check_eq("load_d_ready", 32'(d_ready), 32'h1);
    check_eq("load_d_rdata", d_rdata, memfn(32'h180));
    wait_quiet("load_quiet", 10);

    // store with ack in the fourth mem_req cycle
    force_k = 3;
    d_pend = 1; d_addr = 32'h100; d_we = 1'b1; d_wdata = 32'h1234; d_req = 1'b1;
    lat = 0;
    for (int j = 0; j < 20 && !exp_d_ready; j++) begin step(); lat++; end
    check_eq("store_latency", 32'(lat), 32'd5);
    check_eq("store_d_ready", 32'(d_ready), 32'h1);
    check_eq("store_mem_we", 32'(mem_we), 32'h1);
    check_eq("store_mem_wdata", mem_wdata, 32'h1234);
    check_eq("store_d_rdata_kept", d_rdata, memfn(32'h180));
    wait_quiet("store_quiet", 10);

    // load that the memory never acknowledges
    force_k = -2;
    d_pend = 1; d_addr = 32'h200; d_we = 1'b0; d_req = 1'b1;
    mc = 0;
    for (int j = 0; j < 100 && !exp_d_ready; j++) begin
      step();
      if (mem_req === 1'b1) mc++;
    end
    check_eq("tmo_mem_req_cycles", 32'(mc), 32'(TMO));
    check_eq("tmo_d_ready", 32'(d_ready), 32'h1);
    check_eq("tmo_err", 32'(err), 32'h1);
    check_eq("tmo_d_rdata", d_rdata, 32'h0);
    step();
    check_eq("tmo_err_clear", 32'(err), 32'h0);
    wait_quiet("tmo_quiet", 10);

    // both ports hammering: D,D,D,D,I repeating
    force_k = 0; i_base = 32'h1000_0000; d_base = 32'h2000_0000;
    i_en = 1; d_en = 1; i_always = 1; d_always = 1;
    rec_grants = 1;
    for (int j = 0; j < 40; j++) step();
    rec_grants = 0;
    check_eq("starve_grant_count", 32'(gq.size() >= 10), 32'h1);
    for (int j = 0; j < 10 && j < gq.size(); j++)
      check_eq($sformatf("starve_grant_%0d", j), 32'(gq[j]), (j % 5 == 4) ? 32'h1 : 32'h2);
    i_en = 0; d_en = 0; i_always = 0; d_always = 0;
    wait_quiet("starve_quiet", 50);

    // random traffic with drops, stray acks and timeouts
    force_k = -1; i_base = '0; d_base = '0;
    i_en = 1; d_en = 1; drop_en = 1;
    for (int j = 0; j < 1500; j++) step();

    // reset in the middle of an access
    for (int j = 0; j < 300 && !(m_busy && m_c <= m_len); j++) step();
    check_eq("rst_pre_mem_req", 32'(mem_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    d_en = 0; d_pend = 0; d_drop = 0; d_req = 1'b0;
    i_en = 0; i_drop = 0;
    if (!i_pend) begin i_pend = 1; i_addr = $urandom & 32'hFFFF_FFFC; end
    i_req = 1'b1; mem_ack = 1'b0;
    rst_addr = i_addr;
    @(posedge clk); #1;
    compare_outputs();
    reset = 1'b1;
    step();
    check_eq("rst_restart_req", 32'(mem_req), 32'h1);
    check_eq("rst_restart_addr", mem_addr, rst_addr);
    wait_quiet("rst_quiet", 100);

    // more random traffic, then drain
    i_en = 1; d_en = 1;
    for (int j = 0; j < 800; j++) step();
    i_en = 0; d_en = 0;
    wait_quiet("final_quiet", 400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port (IF) and data-access port (MEM stage load/store). Data accesses have priority so the pipeline drains, with a starvation guard that forces an instruction grant after a bounded data streak. A timeout watchdog completes any access the memory never acknowledges. The pipeline stalls the requesting stage while its `req` is high and `ready` has not yet pulsed; this gates PCWrite/IF_IDWrite on the IF side.

## Interface
Parameters:
- `DATA_W`, 32, data and address width.
- `MAX_DSTREAK`, 4, consecutive contested data grants before IF is forced a grant (≥1).
- `TIMEOUT`, 64, wait cycles in BUSY before forced completion (≥2).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch request, held until `i_ready`.
- `i_addr` in DATA_W: fetch address, stable while `i_req`.
- `i_rdata` out DATA_W: fetched instruction, registered.
- `i_ready` out 1: one-cycle completion pulse for fetch.
- `d_req` in 1: data request, held until `d_ready`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr`, `d_wdata` in DATA_W: data address/write data, stable while `d_req`.
- `d_rdata` out DATA_W: load data, registered.
- `d_ready` out 1: one-cycle completion pulse for data.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_we`, `mem_addr`, `mem_wdata` out 1/DATA_W/DATA_W: latched request fields.
- `mem_rdata` in DATA_W: valid in the cycle `mem_ack` is high.
- `mem_ack` in 1: memory completion, one cycle.
- `busy` out 1: high in BUSY and DONE.
- `err` out 1: one-cycle pulse on timeout completion.

## Operation
- States: IDLE, BUSY, DONE. Owner register `own` (I or D), streak counter `dstreak` (0..MAX_DSTREAK), wait counter `wcnt` (0..TIMEOUT).
- IDLE: no request → stay. Otherwise grant:
  - only `i_req` → I; `dstreak`←0.
  - only `d_req` → D; `dstreak` unchanged.
  - both: if `dstreak`==MAX_DSTREAK → I, `dstreak`←0; else D, `dstreak`←`dstreak`+1.
  - On grant: latch addr/we/wdata into `mem_*` (fetch: `mem_we`=0, `mem_wdata`=0), `mem_req`←1, `wcnt`←0, → BUSY.
- BUSY: `mem_ack`=1 → `mem_req`←0; capture `mem_rdata` into owner's rdata (not for stores: `d_rdata` holds its previous value); owner's ready←1; → DONE. Else `wcnt`←`wcnt`+1; when `wcnt` reaches TIMEOUT−1 without ack: `mem_req`←0, owner's rdata←0 (loads/fetches only), owner's ready←1, `err`←1, → DONE.
- DONE: ready/err←0; → IDLE. No grant in DONE, so a request still held in its ready cycle is not double-serviced.
- `mem_ack` in IDLE or DONE is ignored.
- Requester dropping `req` during BUSY: the access still completes and ready still pulses.
- `mem_addr`/`mem_we`/`mem_wdata` hold last latched values outside BUSY.

## Timing
- All outputs registered. Reset (async, `reset`=0): state IDLE, every output 0, `dstreak`=0, `wcnt`=0; `mem_req` drops immediately, in-flight access abandoned with no ready pulse.
- Zero-wait memory (ack in first `mem_req` cycle): request sampled at edge N → `mem_req` high cycle N+1 → ready high cycle N+2 → IDLE cycle N+3; next grant earliest edge N+3. Throughput one access per 3 cycles.
- Ack after k cycles of `mem_req`: ready pulses k+1 cycles after the grant edge.
- Timeout: `mem_req` high exactly TIMEOUT cycles; ready and `err` in the following cycle.
- `ready` is never high for both ports in the same cycle; at most one ready pulse per grant.

## Test plan
- Reset: drive `reset`=0 mid-BUSY with `mem_req`=1 → `mem_req`, `busy`, all outputs 0 immediately; after release with `i_req`=1, fetch restarts from IDLE.
- Single fetch, zero-wait: `i_addr`=0x40, `mem_rdata`=0x8C220004 with ack in first cycle → `mem_addr`=0x40, `mem_we`=0, `i_ready` pulses 2 cycles after grant edge with `i_rdata`=0x8C220004.
- Priority/starvation, MAX_DSTREAK=4: `i_req` and `d_req` held high continuously → grant order D,D,D,D,I,D,D,D,D,I.
- Store: `d_we`=1, `d_addr`=0x100, `d_wdata`=0x1234, ack after 3 cycles → `mem_we`=1, `mem_wdata`=0x1234, `d_ready` pulse, `d_rdata` unchanged.
- Timeout, TIMEOUT=64: load with `mem_ack` never asserted → `mem_req` high 64 cycles, then `d_ready`=1, `err`=1, `d_rdata`=0 for one cycle.
- Held request: `i_req` kept high through its `i_ready` cycle and `mem_ack` also pulsed in DONE → no extra ready, DONE ack ignored, second fetch granted in IDLE.
